booth_mult_param: RTL and testbench

Parametrised sequential Booth multiplier. It is the successor to the fixed 32-bit HI/LO multiplier used by the CPU datapath for MULT and MULTU. It adds an operand width parameter, signed and unsigned modes, a start/busy/done handshake, and registered HI/LO outputs that hold between operations. The control unit starts it and stalls on multBusy.

---
 rtl/mult_pkg.sv | 34 +++
 rtl/booth_recode.sv | 38 +++
 rtl/booth_mult_param.sv | 124 ++++++++++++
 tb/tb_booth_mult_param.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared state/op types and step-count helpers for booth_mult_param
// BOOTH_MULT_RADIX4_EN selects radix-4 recoding; default build is radix-2.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        BOOTH_NOP  = 3'd0,
        BOOTH_ADD  = 3'd1,
        BOOTH_SUB  = 3'd2,
        BOOTH_ADD2 = 3'd3,
        BOOTH_SUB2 = 3'd4
    } booth_op_e;

`ifdef BOOTH_MULT_RADIX4_EN
    localparam bit RADIX4_EN = 1'b1;
`else
    localparam bit RADIX4_EN = 1'b0;
`endif

    // Operand width after extension: one spare bit for radix-2, two (even) for radix-4.
    function automatic int ext_width(input int width, input bit radix4);
        return radix4 ? width + 2 : width + 1;
    endfunction

    function automatic int step_count(input int width, input bit radix4);
        return radix4 ? (width + 2) / 2 : width + 1;
    endfunction

endpackage

// File: rtl/booth_recode.sv
// rtl/booth_recode.sv - maps a Booth triplet to an op and selects 0/+-M/+-2M
// Radix-2 pairs arrive as {b1,b1,b0}, so one table serves both builds (BOOTH_MULT_RADIX4_EN).
module booth_recode #(
    parameter int EXT = 33
) (
    input  logic [2:0]     triplet,
    input  logic [EXT-1:0] m,
    input  logic [EXT-1:0] neg_m,
    output logic [EXT:0]   addend
);
    import mult_pkg::*;

    booth_op_e op;

    always_comb begin
        op = BOOTH_NOP;
        case (triplet)
            3'b001, 3'b010: op = BOOTH_ADD;
            3'b011:         op = BOOTH_ADD2;
            3'b100:         op = BOOTH_SUB2;
            3'b101, 3'b110: op = BOOTH_SUB;
            default:        op = BOOTH_NOP;
        endcase
    end

    // Addend carries one bit more than M so that 2M and -2M are exact.
    always_comb begin
        addend = '0;
        case (op)
            BOOTH_ADD:  addend = {m[EXT-1], m};
            BOOTH_SUB:  addend = {neg_m[EXT-1], neg_m};
            BOOTH_ADD2: addend = {m, 1'b0};
            BOOTH_SUB2: addend = {neg_m, 1'b0};
            default:    addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_mult_param.sv
// rtl/booth_mult_param.sv - parametrised sequential Booth multiplier with HI/LO outputs
// Radix-4 recoding when BOOTH_MULT_RADIX4_EN is defined, radix-2 otherwise.
module booth_mult_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 2)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             multStart,
    input  logic             signedMode,
    input  logic [WIDTH-1:0] valueA,
    input  logic [WIDTH-1:0] valueB,
    output logic             multBusy,
    output logic             multEnd,
    output logic [WIDTH-1:0] mostSig,
    output logic [WIDTH-1:0] leastSig
);
    import mult_pkg::*;

    localparam int EXT   = ext_width(WIDTH, RADIX4_EN);
    localparam int PW    = 2 * EXT + 1;
    localparam int STEPS = step_count(WIDTH, RADIX4_EN);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STEPS - 1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic [PW-1:0]    p;
    logic [PW-1:0]    p_next;
    logic [EXT-1:0]   m;
    logic [EXT-1:0]   neg_m;
    logic [EXT-1:0]   ext_a;
    logic [EXT-1:0]   ext_b;
    logic [2:0]       triplet;
    logic [EXT:0]     addend;
    logic [EXT:0]     sum;
    logic             last_step;

    assign ext_a     = {{(EXT-WIDTH){valueA[WIDTH-1] & signedMode}}, valueA};
    assign ext_b     = {{(EXT-WIDTH){valueB[WIDTH-1] & signedMode}}, valueB};
    assign last_step = (cnt == LAST);
    assign triplet   = RADIX4_EN ? p[2:0] : {p[1], p[1:0]};

    booth_recode #(.EXT(EXT)) u_recode (
        .triplet (triplet),
        .m       (m),
        .neg_m   (neg_m),
        .addend  (addend)
    );

    // Sum is one bit wider than the upper half; the shift brings it back in range.
    assign sum = {p[PW-1], p[PW-1 -: EXT]} + addend;

    always_comb begin
        if (RADIX4_EN) begin
            p_next = {sum[EXT], sum, p[PW-EXT-1:2]};
        end else begin
            p_next = {sum, p[PW-EXT-1:1]};
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        multBusy   = 1'b0;
        multEnd    = 1'b0;
        case (state)
            IDLE: begin
                if (multStart) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                multBusy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                multEnd    = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            p        <= '0;
            m        <= '0;
            neg_m    <= '0;
            mostSig  <= '0;
            leastSig <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (multStart) begin
                        p     <= {{EXT{1'b0}}, ext_b, 1'b0};
                        m     <= ext_a;
                        neg_m <= -ext_a;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    p   <= p_next;
                    cnt <= cnt + CNT_W'(1);
                    if (last_step) begin
                        {mostSig, leastSig} <= p_next[2*WIDTH:1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_booth_mult_param.sv
// tb/tb_booth_mult_param.sv - scoreboard bench for booth_mult_param (honours BOOTH_MULT_RADIX4_EN)
module tb_booth_mult_param;

    localparam int W = 32;
`ifdef BOOTH_MULT_RADIX4_EN
    localparam int LAT = W / 2 + 2;
`else
    localparam int LAT = W + 2;
`endif
    localparam int N_RAND = 1200;

    logic         clock      = 1'b0;
    logic         reset      = 1'b0;
    logic         multStart  = 1'b0;
    logic         signedMode = 1'b0;
    logic [W-1:0] valueA     = '0;
    logic [W-1:0] valueB     = '0;
    logic         multBusy;
    logic         multEnd;
    logic [W-1:0] mostSig;
    logic [W-1:0] leastSig;

    typedef struct {
        logic [2*W-1:0] prod;
        int             start_edge;
    } exp_t;

    exp_t           sb[$];
    int             edge_count = 0;
    int             next_free  = 0;
    int             n_checks   = 0;
    int             n_pass     = 0;
    logic [2*W-1:0] held       = '0;

    booth_mult_param #(.WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .multStart  (multStart),
        .signedMode (signedMode),
        .valueA     (valueA),
        .valueB     (valueB),
        .multBusy   (multBusy),
        .multEnd    (multEnd),
        .mostSig    (mostSig),
        .leastSig   (leastSig)
    );

    always #5 clock = ~clock;

    always @(posedge clock) edge_count <= edge_count + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s at edge %0d: got %h expected %h", name, edge_count, act, exp);
    endtask

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b,
                                                input logic sm);
        logic signed [2*W-1:0] xa;
        logic signed [2*W-1:0] xb;
        xa = sm ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
        xb = sm ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
        return xa * xb;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b1, {(W-1){1'b0}}};
            3:       return {1'b0, {(W-1){1'b1}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Expected timing: busy on edges [s, s+LAT-2], end pulse after edge s+LAT-1.
    always @(negedge clock) begin
        if (reset) begin
            bit exp_end;
            bit exp_busy;
            exp_end  = 1'b0;
            exp_busy = 1'b0;
            if (sb.size() > 0) begin
                if (edge_count == sb[0].start_edge + LAT - 1) begin
                    exp_end = 1'b1;
                    held    = sb[0].prod;
                    sb.delete(0);
                end else if (edge_count >= sb[0].start_edge) begin
                    exp_busy = 1'b1;
                end
            end
            chk("multEnd", 64'(multEnd), 64'(exp_end));
            chk("multBusy", 64'(multBusy), 64'(exp_busy));
            chk("mostSig", 64'(mostSig), 64'(held[2*W-1:W]));
            chk("leastSig", 64'(leastSig), 64'(held[W-1:0]));
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic sm,
                         input logic [2*W-1:0] prod, input bit hold);
        exp_t e;
        @(negedge clock);
        while (edge_count < next_free) begin
            if (hold) begin
                valueA     = W'($urandom);
                valueB     = W'($urandom);
                signedMode = 1'($urandom);
                multStart  = 1'b1;
            end
            @(negedge clock);
        end
        valueA       = a;
        valueB       = b;
        signedMode   = sm;
        multStart    = 1'b1;
        e.prod       = prod;
        e.start_edge = edge_count + 1;
        sb.push_back(e);
        next_free    = e.start_edge + LAT;
        @(negedge clock);
        if (!hold) multStart = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sm;

        #12;
        chk("reset_busy", 64'(multBusy), 64'd0);
        chk("reset_end", 64'(multEnd), 64'd0);
        chk("reset_hi", 64'(mostSig), 64'd0);
        chk("reset_lo", 64'(leastSig), 64'd0);
        @(negedge clock);
        #2 reset = 1'b1;
        next_free = edge_count;

        issue(32'd3, 32'hFFFF_FFFC, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFF4}, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, {32'hFFFF_FFFE, 32'h0000_0001}, 1'b0);
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, {32'h0000_0000, 32'h0000_0001}, 1'b0);
        issue(32'h8000_0000, 32'h8000_0000, 1'b1, {32'h4000_0000, 32'h0000_0000}, 1'b0);
        issue(32'h0000_0000, 32'h1234_5678, 1'b0, 64'd0, 1'b0);

        // Start re-pulsed mid-run with new operands must be ignored.
        issue(32'd7, 32'd9, 1'b0, 64'd63, 1'b0);
        repeat (10) @(negedge clock);
        valueA     = 32'hDEAD_BEEF;
        valueB     = 32'h1234_5678;
        signedMode = 1'b1;
        multStart  = 1'b1;
        @(negedge clock);
        multStart  = 1'b0;
        repeat (LAT + 6) @(negedge clock);

        // Asynchronous reset in the middle of a run.
        issue(32'd5, 32'd6, 1'b1, 64'd30, 1'b0);
        repeat (14) @(posedge clock);
        #2 reset = 1'b0;
        sb.delete();
        held = '0;
        #1;
        chk("async_busy", 64'(multBusy), 64'd0);
        chk("async_end", 64'(multEnd), 64'd0);
        chk("async_hi", 64'(mostSig), 64'd0);
        chk("async_lo", 64'(leastSig), 64'd0);
        repeat (2) @(posedge clock);
        #3 reset = 1'b1;
        next_free = edge_count;
        issue(32'hFFFF_FFFB, 32'd7, 1'b1, {32'hFFFF_FFFF, 32'hFFFF_FFDD}, 1'b0);

        for (int i = 0; i < N_RAND; i++) begin
            a  = pick();
            b  = pick();
            sm = 1'($urandom);
            issue(a, b, sm, ref_prod(a, b, sm), 1'b1);
        end
        @(negedge clock);
        multStart = 1'b0;
        repeat (LAT + 4) @(negedge clock);
        chk("drain", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
